// File: rtl/prog_rom_loader.sv
// 16 x 8-bit instruction store feeding the 4-bit CPU: combinational ROM-style
// read, valid/ready program load port, and a CPU-reset control FSM.
module prog_rom_loader #(
    parameter int LOAD_WORDS = 16,
    parameter bit AUTO_RUN   = 1'b1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [3:0] addr,
    output logic [3:0] opecode,
    output logic [3:0] imm,
    input  logic       load_start,
    input  logic       run,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic       load_done,
    output logic       cpu_n_rst,
    output logic       loading
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(LOAD_WORDS - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_mem [16];
    logic [3:0] r_wptr;
    logic       w_write;
    logic       w_last;
    logic       w_ready_nxt;
    logic       w_cpu_nxt;
    logic       w_done_nxt;
    logic       r_load_ready;
    logic       r_load_done;
    logic       r_cpu_n_rst;
    logic       r_loading;

    assign opecode    = r_mem[addr][7:4];
    assign imm        = r_mem[addr][3:0];
    assign load_ready = r_load_ready;
    assign load_done  = r_load_done;
    assign cpu_n_rst  = r_cpu_n_rst;
    assign loading    = r_loading;

    // Write decode: a restart in the same cycle discards the handshaked word.
    always_comb begin
        w_write = 1'b0;
        w_last  = 1'b0;
        if ((r_state == S_LOAD) && load_valid && !load_start) begin
            w_write = 1'b1;
            w_last  = (r_wptr == LAST_IDX);
        end else begin
            w_write = 1'b0;
            w_last  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; load_start always (re)enters LOAD and has priority over run.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_next = S_LOAD;
                end else if (run) begin
                    w_next = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_LOAD: begin
                if (load_start) begin
                    w_next = S_LOAD;
                end else if (w_last) begin
                    w_next = AUTO_RUN ? S_RUN : S_IDLE;
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_RUN: begin
                if (load_start) begin
                    w_next = S_LOAD;
                end else begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs track the FSM edge.
    always_comb begin
        w_ready_nxt = 1'b0;
        w_cpu_nxt   = 1'b0;
        w_done_nxt  = w_last;
        case (w_next)
            S_IDLE:  begin w_ready_nxt = 1'b0; w_cpu_nxt = 1'b0; end
            S_LOAD:  begin w_ready_nxt = 1'b1; w_cpu_nxt = 1'b0; end
            S_RUN:   begin w_ready_nxt = 1'b0; w_cpu_nxt = 1'b1; end
            default: begin w_ready_nxt = 1'b0; w_cpu_nxt = 1'b0; end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_load_ready <= 1'b0;
            r_loading    <= 1'b0;
            r_cpu_n_rst  <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_load_ready <= w_ready_nxt;
            r_loading    <= w_ready_nxt;
            r_cpu_n_rst  <= w_cpu_nxt;
            r_load_done  <= w_done_nxt;
        end
    end

    // Program store and write pointer; any load_start clears the whole store.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wptr <= 4'd0;
        end else if (load_start) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wptr <= 4'd0;
        end else if (w_write) begin
            r_mem[r_wptr] <= load_data;
            r_wptr        <= w_last ? 4'd0 : (r_wptr + 4'd1);
        end else begin
            r_wptr <= r_wptr;
        end
    end

endmodule

// File: tb/tb_prog_rom_loader.sv
// Randomized bench for prog_rom_loader: a full/auto-run instance and a short/manual-run
// instance share stimulus and are compared every cycle against a word-count model.
`timescale 1ns/1ps
module tb_prog_rom_loader;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] addr;
    logic       load_start, run, load_valid;
    logic [7:0] load_data;

    logic [3:0] a_ope, a_imm, b_ope, b_imm;
    logic       a_ready, a_done, a_cpu, a_loading;
    logic       b_ready, b_done, b_cpu, b_loading;

    always #5 clk = ~clk;

    prog_rom_loader #(.LOAD_WORDS(16), .AUTO_RUN(1'b1)) u_full (
        .clk(clk), .n_rst(n_rst), .addr(addr), .opecode(a_ope), .imm(a_imm),
        .load_start(load_start), .run(run), .load_valid(load_valid), .load_data(load_data),
        .load_ready(a_ready), .load_done(a_done), .cpu_n_rst(a_cpu), .loading(a_loading)
    );

    prog_rom_loader #(.LOAD_WORDS(4), .AUTO_RUN(1'b0)) u_short (
        .clk(clk), .n_rst(n_rst), .addr(addr), .opecode(b_ope), .imm(b_imm),
        .load_start(load_start), .run(run), .load_valid(load_valid), .load_data(load_data),
        .load_ready(b_ready), .load_done(b_done), .cpu_n_rst(b_cpu), .loading(b_loading)
    );

    // Reference model: index 0 = full/auto-run instance, 1 = short/manual instance.
    logic [7:0] m_mem [2][16];
    bit         m_ld [2];
    bit         m_rn [2];
    bit         m_dn [2];
    int         m_cnt [2];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int k);
        for (int i = 0; i < 16; i++) m_mem[k][i] = 8'h00;
        m_cnt[k] = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            model_clear(k);
            m_ld[k] = 1'b0;
            m_rn[k] = 1'b0;
            m_dn[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit ls, input bit rn, input bit v, input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            int lw;
            lw = (k == 0) ? 16 : 4;
            m_dn[k] = 1'b0;
            if (m_ld[k]) begin
                if (ls) begin
                    model_clear(k);
                end else if (v) begin
                    m_mem[k][m_cnt[k]] = d;
                    m_cnt[k]++;
                    if (m_cnt[k] == lw) begin
                        m_ld[k]  = 1'b0;
                        m_rn[k]  = (k == 0);
                        m_dn[k]  = 1'b1;
                        m_cnt[k] = 0;
                    end
                end
            end else if (ls) begin
                model_clear(k);
                m_ld[k] = 1'b1;
                m_rn[k] = 1'b0;
            end else if (!m_rn[k] && rn) begin
                m_rn[k] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, "/f_ready"},   32'(a_ready),   32'(m_ld[0]));
        chk({ph, "/f_loading"}, 32'(a_loading), 32'(m_ld[0]));
        chk({ph, "/f_cpu"},     32'(a_cpu),     32'(m_rn[0]));
        chk({ph, "/f_done"},    32'(a_done),    32'(m_dn[0]));
        chk({ph, "/f_read"},    32'({a_ope, a_imm}), 32'(m_mem[0][addr]));
        chk({ph, "/s_ready"},   32'(b_ready),   32'(m_ld[1]));
        chk({ph, "/s_loading"}, 32'(b_loading), 32'(m_ld[1]));
        chk({ph, "/s_cpu"},     32'(b_cpu),     32'(m_rn[1]));
        chk({ph, "/s_done"},    32'(b_done),    32'(m_dn[1]));
        chk({ph, "/s_read"},    32'({b_ope, b_imm}), 32'(m_mem[1][addr]));
    endtask

    task automatic cycle(input string ph, input bit ls, input bit rn, input bit v,
                         input logic [7:0] d, input logic [3:0] a);
        @(negedge clk);
        load_start = ls;
        run        = rn;
        load_valid = v;
        load_data  = d;
        addr       = a;
        @(posedge clk);
        model_step(ls, rn, v, d);
        #1;
        check_all(ph);
    endtask

    task automatic idle(input string ph);
        cycle(ph, 1'b0, 1'b0, 1'b0, 8'($urandom), 4'($urandom_range(0, 15)));
    endtask

    task automatic sweep(input string ph);
        for (int a = 0; a < 16; a++) cycle(ph, 1'b0, 1'b0, 1'b0, 8'($urandom), 4'(a));
    endtask

    task automatic async_reset(input string ph);
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all(ph);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic load_words(input string ph, input int n);
        for (int i = 0; i < n; i++)
            cycle(ph, 1'b0, 1'b0, 1'b1, 8'($urandom), 4'($urandom_range(0, 15)));
    endtask

    initial begin
        logic [7:0] w;
        n_rst = 1'b0; load_start = 1'b0; run = 1'b0; load_valid = 1'b0;
        load_data = 8'h00; addr = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        n_rst = 1'b1;
        sweep("reset_sweep");

        // Full back-to-back load B3, ..., F0.
        cycle("full_start", 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 16; i++) begin
            w = (i == 0) ? 8'hB3 : (i == 15) ? 8'hF0 : 8'($urandom);
            cycle("full_load", 1'b0, 1'b0, 1'b1, w, 4'($urandom_range(0, 15)));
        end
        chk("full_done_pulse", 32'(a_done), 32'd1);
        chk("full_cpu_release", 32'(a_cpu), 32'd1);
        idle("full_after");
        chk("full_done_one_cycle", 32'(a_done), 32'd0);
        cycle("full_addr0", 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
        chk("full_addr0_word", 32'({a_ope, a_imm}), 32'h0B3);
        cycle("full_addr15", 1'b0, 1'b0, 1'b0, 8'h00, 4'd15);
        chk("full_addr15_word", 32'({a_ope, a_imm}), 32'h0F0);

        // Handshake gaps: valid toggles, data on stalled cycles must never land.
        cycle("gap_start", 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 32; i++)
            cycle("gap_load", 1'b0, 1'b0, (i % 2) == 0, 8'($urandom), 4'($urandom_range(0, 15)));
        sweep("gap_sweep");

        // Restart mid-load with a concurrent handshake of 0xAA.
        cycle("rst_start", 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        load_words("rst_pre", 5);
        cycle("restart", 1'b1, 1'b0, 1'b1, 8'hAA, 4'd0);
        sweep("restart_sweep");
        cycle("rst_first", 1'b0, 1'b0, 1'b1, 8'h5C, 4'd0);
        chk("restart_addr0", 32'({a_ope, a_imm}), 32'h05C);

        // Short instance: 4 words then IDLE, release only on run.
        cycle("short_start", 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        cycle("short_load", 1'b0, 1'b0, 1'b1, 8'h31, 4'd0);
        cycle("short_load", 1'b0, 1'b0, 1'b1, 8'h72, 4'd1);
        cycle("short_load", 1'b0, 1'b0, 1'b1, 8'h93, 4'd2);
        cycle("short_load", 1'b0, 1'b0, 1'b1, 8'hB4, 4'd3);
        chk("short_done", 32'(b_done), 32'd1);
        chk("short_cpu_held", 32'(b_cpu), 32'd0);
        chk("short_idle", 32'(b_loading), 32'd0);
        sweep("short_sweep");
        cycle("short_run", 1'b0, 1'b1, 1'b0, 8'h00, 4'd3);
        chk("short_run_release", 32'(b_cpu), 32'd1);

        // Finish the full load to reach RUN, then reload from RUN.
        load_words("full_finish", 12);
        idle("in_run");
        cycle("reload", 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        chk("reload_cpu_drop", 32'(a_cpu), 32'd0);
        chk("reload_loading", 32'(a_loading), 32'd1);
        load_words("reload_words", 6);
        async_reset("reset_mid_load");
        sweep("post_reset_sweep");

        // Async reset while running must drop cpu_n_rst before any clock edge.
        cycle("run_start", 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        load_words("run_load", 16);
        idle("running");
        async_reset("reset_in_run");

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            cycle("random", $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) != 0, 8'($urandom), 4'($urandom_range(0, 15)));
        sweep("final_sweep");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_rom_loader.md
Name: prog_rom_loader

Overview:
16-word x 8-bit instruction store that sits directly upstream of the 4-bit CPU core. It decodes the CPU's 4-bit `addr` into `opecode`/`imm`, using a combinational read like a ROM. A byte-wide valid/ready load port writes programs into the store. A small FSM holds the CPU in reset while it is idle or loading, and releases the CPU once a program is in place.

Parameters:
LOAD_WORDS, 16, number of words accepted per load (legal range 1..16); entries at or above LOAD_WORDS read as 0x00 after a load.
AUTO_RUN, 1, if 1 the FSM goes LOAD->RUN when the last word is written; if 0 it goes LOAD->IDLE.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
n_rst  input  1  reset, asynchronous and active-low.
addr  input  4  instruction address from the CPU.
opecode  output  4  mem[addr][7:4], combinational.
imm  output  4  mem[addr][3:0], combinational.
load_start  input  1  begin (or restart) a program load.
run  input  1  release the CPU with the current contents (honoured in IDLE only).
load_valid  input  1  load_data is valid this cycle.
load_data  input  8  instruction word {opecode, imm}.
load_ready  output  1  high in LOAD only; handshake completes on valid&&ready.
load_done  output  1  one-cycle pulse, registered, the cycle after the last word is written.
cpu_n_rst  output  1  active-low reset to the CPU; registered, high only while the FSM is in RUN.
loading  output  1  high while in LOAD.

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE, all 16 mem entries=0x00, wptr=0.
  - cpu_n_rst=0, load_done=0, load_ready=0, loading=0.
- Read path: `opecode`/`imm` are a pure combinational function of `addr` and mem in every state, with zero latency.
- States are IDLE, LOAD and RUN.
- IDLE:
  - load_start -> LOAD.
  - Else run -> RUN.
  - If both are high, load_start wins.
- Entering LOAD, on the transition edge:
  - all mem entries are cleared to 0x00 and wptr=0.
  - The cycle after load_start is therefore the first cycle with load_ready=1.
- LOAD write path:
  - On load_valid&&load_ready, mem[wptr]<=load_data and wptr<=wptr+1.
  - A written value is visible on the read path the next cycle.
- LOAD end:
  - Writing entry LOAD_WORDS-1 moves the FSM to RUN (AUTO_RUN=1) or IDLE (AUTO_RUN=0) on that same edge.
  - wptr returns to 0 and load_done pulses for exactly one cycle.
- load_start while in LOAD restarts the load:
  - mem is cleared and wptr=0.
  - Any write handshaked in that same cycle is discarded.
- load_start while in RUN -> LOAD, which resets the CPU. run is ignored in LOAD and RUN.
- cpu_n_rst is registered from (next_state==RUN). It rises on the same edge the FSM enters RUN and falls on the same edge it leaves RUN.
- The CPU's first fetch after release is addr=0, which the CPU supplies after its own reset.
- wptr is a 4-bit counter with no wrap inside a load: the terminal write always ends the load.
- load_valid outside LOAD has no effect; data is dropped and mem is unchanged.
- n_rst asserted mid-load aborts the load: mem is cleared, the FSM returns to IDLE, and cpu_n_rst=0 immediately (asynchronously).

Test Plan:
- Reset then idle: n_rst low for 2 cycles -> opecode=0, imm=0 for every addr 0..15; cpu_n_rst=0; load_ready=0.
- Full load, AUTO_RUN=1: load_start, then 16 back-to-back words 0xB3,0x01,...,0xF0 -> load_done pulses once after word 15; cpu_n_rst=1 the same cycle; addr=0 reads opecode=0xB, imm=0x3; addr=15 reads opecode=0xF, imm=0x0.
- Handshake gaps: load_valid toggles 1/0 over 16 words -> exactly 16 writes; stalled cycles leave wptr unchanged; load_data presented in a cycle with load_valid=0 is never stored.
- Restart mid-load: write 5 words, then assert load_start together with load_valid (data 0xAA) -> all entries read 0x00; the next accepted word lands at addr 0; 0xAA is absent.
- Short load, LOAD_WORDS=4, AUTO_RUN=0: load 0x31,0x72,0x93,0xB4 -> FSM enters IDLE; cpu_n_rst stays 0; addr 4..15 read 0x00; a later run pulse sets cpu_n_rst=1 the next edge.
- Reload from RUN: in RUN assert load_start -> cpu_n_rst drops on the next edge; loading=1; prior contents cleared; reset mid-LOAD returns to IDLE with cpu_n_rst=0 asynchronously.
